// File: rtl/dsp48a1_pkg.sv
// Shared DSP48A1 constants: operand port widths, clear-mode encoding and
// the occupancy-counter width helper used by the pipe chain.
package dsp48a1_pkg;

    localparam int A_W    = 18;
    localparam int B_W    = 18;
    localparam int D_W    = 18;
    localparam int C_W    = 48;
    localparam int P_W    = 48;
    localparam int PCIN_W = 48;

    // CLR_ZERO encoding: keep data on clear, or zero it along with valid.
    localparam bit CLR_KEEP_DATA = 1'b0;
    localparam bit CLR_ZERO_DATA = 1'b1;

    typedef enum logic [2:0] {
        PORT_A, PORT_B, PORT_C, PORT_D, PORT_P, PORT_PCIN
    } dsp_port_e;

    function automatic int port_w(input dsp_port_e p);
        case (p)
            PORT_A:  return A_W;
            PORT_B:  return B_W;
            PORT_C:  return C_W;
            PORT_D:  return D_W;
            PORT_P:  return P_W;
            default: return PCIN_W;
        endcase
    endfunction

    // Counter must hold 0..DEPTH; sized with headroom so DEPTH=0 still gives 1 bit.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/dsp48a1_pipe_stage.sv
// One valid/data register stage of the bubble-collapsing pipe chain.
// Loads when enabled and its ready is high; clear has priority over ce.
module dsp48a1_pipe_stage
    import dsp48a1_pkg::*;
#(
    parameter int WIDTH    = A_W,
    parameter bit CLR_ZERO = CLR_ZERO_DATA
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             clr,
    input  logic             rdy,
    input  logic             vin,
    input  logic [WIDTH-1:0] din,
    output logic             v,
    output logic             v_nxt,
    output logic [WIDTH-1:0] d
);

    logic load;
    assign load = ce & rdy;

    // Next valid is exported so the top can register occupancy on the same edge.
    always_comb begin
        v_nxt = v;
        if (clr) begin
            v_nxt = 1'b0;
        end else if (load) begin
            v_nxt = vin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= 1'b0;
        end else begin
            v <= v_nxt;
        end
    end

    // Data only moves with a valid item, so bubbles never toggle the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d <= '0;
        end else if (clr) begin
            if (CLR_ZERO) begin
                d <= '0;
            end
        end else if (load && vin) begin
            d <= din;
        end
    end

endmodule

// File: rtl/dsp48a1_pipe_chain.sv
// DEPTH-stage valid/ready retiming pipe for DSP48A1 operand and P paths.
// Bubbles collapse through the combinational ready chain; DEPTH=0 is a wire.
module dsp48a1_pipe_chain
    import dsp48a1_pkg::*;
#(
    parameter int WIDTH    = A_W,
    parameter int DEPTH    = 1,
    parameter bit CLR_ZERO = CLR_ZERO_DATA
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ce,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [occ_w(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_w(DEPTH);

    generate
        if (DEPTH == 0) begin : g_comb
            assign in_ready  = out_ready & ce & ~clr;
            assign out_valid = in_valid & ce & ~clr;
            assign out_data  = in_data;
            assign occupancy = '0;

            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
        end else begin : g_pipe
            // Index 0 of each chain is the upstream side; index i+1 is stage i.
            logic [DEPTH:0]   v_chain;
            logic [DEPTH-1:0] v_nxt;
            logic [DEPTH:0]   rdy;
            logic [WIDTH-1:0] d_chain [DEPTH+1];
            logic [OCC_W-1:0] occ_nxt;
            logic [OCC_W-1:0] occ_q;

            assign v_chain[0] = in_valid;
            assign d_chain[0] = in_data;
            assign rdy[DEPTH] = out_ready;

            for (genvar i = 0; i < DEPTH; i++) begin : g_stage
                assign rdy[i] = ~v_chain[i+1] | rdy[i+1];

                dsp48a1_pipe_stage #(
                    .WIDTH    (WIDTH),
                    .CLR_ZERO (CLR_ZERO)
                ) u_stage (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .ce    (ce),
                    .clr   (clr),
                    .rdy   (rdy[i]),
                    .vin   (v_chain[i]),
                    .din   (d_chain[i]),
                    .v     (v_chain[i+1]),
                    .v_nxt (v_nxt[i]),
                    .d     (d_chain[i+1])
                );
            end

            always_comb begin
                occ_nxt = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    occ_nxt = occ_nxt + OCC_W'(v_nxt[i]);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    occ_q <= '0;
                end else begin
                    occ_q <= occ_nxt;
                end
            end

            // Masking out_valid during clr keeps a downstream handshake from completing.
            assign in_ready  = ce & ~clr & rdy[0];
            assign out_valid = v_chain[DEPTH] & ~clr;
            assign out_data  = d_chain[DEPTH];
            assign occupancy = occ_q;
        end
    endgenerate

endmodule

// File: tb/tb_dsp48a1_pipe_chain.sv
// Scoreboard bench for dsp48a1_pipe_chain: DEPTH=3 pipe with a monitor-driven
// expected queue, plus a DEPTH=0 pass-through instance checked directly.
module tb_dsp48a1_pipe_chain;

    localparam int W = 18;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ce, clr, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [2:0]   occupancy;

    logic         ce0, clr0, in_valid0, out_ready0;
    logic [W-1:0] in_data0;
    logic         in_ready0, out_valid0;
    logic [W-1:0] out_data0;
    logic [0:0]   occupancy0;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    dsp48a1_pipe_chain #(.WIDTH(W), .DEPTH(3), .CLR_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    dsp48a1_pipe_chain #(.WIDTH(W), .DEPTH(0), .CLR_ZERO(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .ce(ce0), .clr(clr0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .occupancy(occupancy0)
    );

    // Monitor: a pop happens at the next edge when valid, ready and ce all hold.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && ce && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected got=%h required=none", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL mon_data got=%h required=%h", out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one item and hold it until accepted; record it as expected output.
    task automatic send(input logic [W-1:0] data);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = data;
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back(data);
                done = 1;
            end
            step();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=stalled required=accept data=%h", data);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0;
        ce0 = 1'b1; clr0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; in_data0 = '0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Back-to-back stream with out_ready high: 3-cycle latency, full throughput.
        out_ready = 1'b1;
        send(18'h00001);
        chk("t1_occ_after1",   32'(occupancy), 32'd1);
        chk("t1_valid_after1", 32'(out_valid), 32'd0);
        send(18'h00002);
        chk("t1_valid_after2", 32'(out_valid), 32'd0);
        send(18'h00003);
        chk("t1_valid_after3", 32'(out_valid), 32'd1);
        chk("t1_data_after3",  32'(out_data),  32'h00001);
        chk("t1_occ_after3",   32'(occupancy), 32'd3);
        send(18'h00004);
        send(18'h00005);
        chk("t1_occ_steady",   32'(occupancy), 32'd3);
        chk("t1_valid_steady", 32'(out_valid), 32'd1);
        repeat (4) step();
        chk("t1_occ_drained",  32'(occupancy), 32'd0);

        // Stall: three accepts fill the chain, then in_ready drops.
        out_ready = 1'b0;
        send(18'h00011); send(18'h00012); send(18'h00013);
        in_valid = 1'b1; in_data = 18'h00014;
        #1;
        chk("t2_full_in_ready", 32'(in_ready),  32'd0);
        chk("t2_full_occ",      32'(occupancy), 32'd3);
        chk("t2_full_head",     32'(out_data),  32'h00011);
        out_ready = 1'b1;
        #1;
        chk("t2_pop_push_ready", 32'(in_ready), 32'd1);
        send(18'h00014);
        send(18'h00015);
        repeat (4) step();

        // Bubble collapse: B slides up behind A while the output is stalled.
        out_ready = 1'b0;
        send(18'h2AAAA);
        step(); step();
        send(18'h15555);
        step(); step();
        chk("t3_occ_two",   32'(occupancy), 32'd2);
        chk("t3_head_a",    32'(out_data),  32'h2AAAA);
        chk("t3_in_ready",  32'(in_ready),  32'd1);
        out_ready = 1'b1;
        step();
        chk("t3_b_next_valid", 32'(out_valid), 32'd1);
        chk("t3_b_next_data",  32'(out_data),  32'h15555);
        step(); step();

        // Clear with data zeroing; an item offered during clr must be refused.
        out_ready = 1'b0;
        send(18'h3FFFF); send(18'h3FFFF); send(18'h3FFFF);
        clr = 1'b1; in_valid = 1'b1; in_data = 18'h00077;
        #1;
        chk("t4_clr_in_ready",  32'(in_ready),  32'd0);
        chk("t4_clr_out_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        step();
        clr = 1'b0; in_valid = 1'b0;
        chk("t4_post_valid", 32'(out_valid), 32'd0);
        chk("t4_post_occ",   32'(occupancy), 32'd0);
        chk("t4_post_data",  32'(out_data),  32'd0);
        out_ready = 1'b1;
        repeat (4) step();

        // Clock-enable freeze with downstream ready: nothing pops, nothing moves.
        send(18'h00021); send(18'h00022); send(18'h00023);
        ce = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_frz_data",     32'(out_data),  32'h00021);
            chk("t5_frz_occ",      32'(occupancy), 32'd3);
            chk("t5_frz_in_ready", 32'(in_ready),  32'd0);
            step();
        end
        ce = 1'b1;
        send(18'h00024);
        repeat (4) step();

        // Asynchronous reset between edges while full.
        out_ready = 1'b0;
        send(18'h00031); send(18'h00032); send(18'h00033);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_valid", 32'(out_valid), 32'd0);
        chk("t6_arst_data",  32'(out_data),  32'd0);
        chk("t6_arst_occ",   32'(occupancy), 32'd0);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        send(18'h00035);
        step();
        chk("t6_restart_occ", 32'(occupancy), 32'd1);
        repeat (3) step();

        // DEPTH=0 pass-through.
        in_valid0 = 1'b1; out_ready0 = 1'b1; in_data0 = 18'h12345;
        #1;
        chk("d0_data",     32'(out_data0),   32'h12345);
        chk("d0_valid",    32'(out_valid0),  32'd1);
        chk("d0_in_ready", 32'(in_ready0),   32'd1);
        chk("d0_occ",      32'(occupancy0),  32'd0);
        in_data0 = 18'h0ABCD;
        #1;
        chk("d0_data2",    32'(out_data0),   32'h0ABCD);
        out_ready0 = 1'b0;
        #1;
        chk("d0_backpress", 32'(in_ready0),  32'd0);
        out_ready0 = 1'b1; clr0 = 1'b1;
        #1;
        chk("d0_clr_valid", 32'(out_valid0), 32'd0);
        chk("d0_clr_ready", 32'(in_ready0),  32'd0);
        clr0 = 1'b0; ce0 = 1'b0;
        #1;
        chk("d0_ce_valid",  32'(out_valid0), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
